tfc_delay_ring: RTL and testbench
=================================

TFC_DELAY_RING -- requirements
Module: tfc_delay_ring

Interface
REQ-001 The block SHALL have parameter DEPTH, default 256, giving ring buffer entries; it SHALL be a power of two, minimum 4.
REQ-002 The block SHALL have parameter TFC_WIDTH, default 8, giving bits per channel.
REQ-003 The block SHALL have parameter NUM_CH, default 2, giving independent data channels that share one delay.
REQ-004 The block SHALL have parameter MAX_DELAY, default DEPTH-1, giving the largest legal delay; it SHALL be at most DEPTH-1.
REQ-005 The block SHALL have port main_clk, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-006 The block SHALL have port rst_n, input, 1 bit: reset, asynchronous and active-low.
REQ-007 The block SHALL have port delay_in, input, AW bits (AW = clog2(DEPTH)): requested delay D.
REQ-008 The block SHALL have port delay_load, input, 1 bit: a one-cycle strobe that applies delay_in.
REQ-009 The block SHALL have port tfc_in, input, NUM_CH*TFC_WIDTH bits: channel c occupies bits [c*TFC_WIDTH +: TFC_WIDTH].
REQ-010 The block SHALL have port tfc_out, output, NUM_CH*TFC_WIDTH bits: delayed data, registered.
REQ-011 The block SHALL have port out_valid, output, 1 bit: tfc_out carries real delayed data.
REQ-012 The block SHALL have port delay_cur, output, AW bits: the delay currently in force.
REQ-013 The block SHALL have port delay_err, output, 1 bit: sticky flag, set by an illegal delay request.

Function
REQ-014 tfc_in SHALL be written into the ring every cycle at wr_ptr; wr_ptr SHALL increment modulo DEPTH and wrap from DEPTH-1 to 0 with no gap.
REQ-015 In RUN, tfc_out SHALL present the tfc_in sampled at edge k on edge k+D+1, for every channel; D=0 gives one cycle of latency.
REQ-016 The read address SHALL be wr_ptr-D modulo DEPTH, using AW-bit unsigned wrap arithmetic.
REQ-017 The FSM SHALL have three states: IDLE (reset), FILL and RUN.
REQ-018 IDLE SHALL go to FILL on the first cycle after reset release, using D = delay_cur.
REQ-019 In FILL, a fill counter SHALL count written entries; when it reaches D+1 the FSM SHALL go to RUN.
REQ-020 On the edge that enters RUN, out_valid SHALL rise together with the first valid tfc_out.
REQ-021 In IDLE and FILL, out_valid SHALL be 0 and tfc_out SHALL be forced to all zeros; ring contents from before the fill SHALL never appear on tfc_out.
REQ-022 A delay_load with delay_in <= MAX_DELAY SHALL update delay_cur on the next edge, clear delay_err, go to FILL and restart the fill counter at 0.
REQ-023 A delay_load with delay_in > MAX_DELAY SHALL clamp: delay_cur becomes MAX_DELAY, delay_err is set, and the FSM goes to FILL.
REQ-024 A delay_load that arrives while already in FILL SHALL restart the fill with the new D.
REQ-025 Writes SHALL continue during FILL; wr_ptr SHALL never stall or reset except on rst_n.
REQ-026 A delay_load on the same cycle that FILL would complete SHALL take priority, and the FSM SHALL stay in FILL.
REQ-027 A delay_load with delay_in equal to delay_cur SHALL still restart FILL, so the behaviour is deterministic.

Reset
REQ-028 While rst_n is low: tfc_out = 0, out_valid = 0, delay_err = 0, delay_cur = MAX_DELAY, wr_ptr = 0, fill counter = 0, state = IDLE.
REQ-029 The ring storage array SHALL NOT be reset; REQ-021 guarantees that unreset contents are never output.
REQ-030 Asserting reset mid-operation SHALL abort FILL or RUN immediately (asynchronously); the first post-release output behaviour SHALL match power-up.

Structure
REQ-031 Package tfc_delay_pkg SHALL hold the FSM state enum (IDLE, FILL, RUN) and the default parameter constants.
REQ-032 The storage SHALL be a sub-module tfc_delay_mem: a 1-write/1-read register array with registered read and no reset.
REQ-033 Pointer, fill counter, FSM and delay register SHALL live in tfc_delay_ring; the expected size is 150-300 lines in total.

Verification
REQ-034 Reset, then delay_load with delay_in=5, then a ramp 1,2,3... on channel 0 -> out_valid rises exactly 6 cycles after the load takes effect, and tfc_out[ch0] lags the input by exactly 6 cycles.
REQ-035 D=0 with a random stream on both channels -> 1-cycle latency; channel 1 is independent of channel 0.
REQ-036 MAX_DELAY=200, delay_in=250 -> delay_err=1, delay_cur=200, latency 201; a later load of 10 clears delay_err.
REQ-037 D=DEPTH-1=255 for 600 cycles -> correct data across at least two wr_ptr wraps, with no glitch at the wrap.
REQ-038 In RUN with D=20, load D=3 -> out_valid drops on the next edge, tfc_out=0, and valid 3-cycle-delayed data returns after 4 cycles.
REQ-039 Assert rst_n low mid-FILL and mid-RUN -> all outputs go to reset values immediately, and post-release behaviour matches REQ-034 with D=MAX_DELAY.

Source files
------------

// File: rtl/tfc_delay_pkg.sv
// tfc_delay_pkg: shared definitions for the TFC delay ring.
//   - Default geometry constants (depth, channel width, channel count).
//   - FSM state encodings as plain constants, plus the enum built on them.
package tfc_delay_pkg;

  localparam int TFC_DEPTH_DEF  = 256;
  localparam int TFC_WIDTH_DEF  = 8;
  localparam int TFC_NUM_CH_DEF = 2;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_FILL = 2'd1;
  localparam logic [1:0] ST_RUN  = 2'd2;

  typedef enum logic [1:0] {
    IDLE = ST_IDLE,
    FILL = ST_FILL,
    RUN  = ST_RUN
  } tfc_state_e;

endpackage

// File: rtl/tfc_delay_ring_if.sv
// tfc_delay_ring_if: data and control bundle of the TFC delay ring.
//   delay_in   : requested delay D (AW bits)
//   delay_load : one-cycle strobe applying delay_in
//   tfc_in     : NUM_CH packed channels, channel c at [c*TFC_WIDTH +: TFC_WIDTH]
//   tfc_out    : delayed channels, registered, zero while not running
//   out_valid  : tfc_out carries real delayed data
//   delay_cur  : delay currently in force
//   delay_err  : sticky, set by an out-of-range delay request
// Modports: master drives requests and data, slave is the delay ring.
interface tfc_delay_ring_if
  import tfc_delay_pkg::*;
#(
  parameter int DEPTH     = TFC_DEPTH_DEF,
  parameter int TFC_WIDTH = TFC_WIDTH_DEF,
  parameter int NUM_CH    = TFC_NUM_CH_DEF
);
  localparam int AW = $clog2(DEPTH);
  localparam int BW = NUM_CH * TFC_WIDTH;

  logic [AW-1:0] delay_in;
  logic          delay_load;
  logic [BW-1:0] tfc_in;
  logic [BW-1:0] tfc_out;
  logic          out_valid;
  logic [AW-1:0] delay_cur;
  logic          delay_err;

  modport master (
    output delay_in, delay_load, tfc_in,
    input  tfc_out, out_valid, delay_cur, delay_err
  );

  modport slave (
    input  delay_in, delay_load, tfc_in,
    output tfc_out, out_valid, delay_cur, delay_err
  );

endinterface

// File: rtl/tfc_delay_mem.sv
// tfc_delay_mem: 1-write / 1-read register array with registered read.
//   clk        : rising-edge clock
//   we         : write enable
//   wr_addr    : write address
//   wr_data    : write data
//   rd_addr    : read address
//   rd_data_p0 : registered read data
// No reset on the storage. A read of the address being written in the same
// cycle returns the new data, so a zero-distance read sees this cycle's write.
module tfc_delay_mem
  import tfc_delay_pkg::*;
#(
  parameter int DEPTH = TFC_DEPTH_DEF,
  parameter int WIDTH = TFC_WIDTH_DEF * TFC_NUM_CH_DEF,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             we,
  input  logic [AW-1:0]    wr_addr,
  input  logic [WIDTH-1:0] wr_data,
  input  logic [AW-1:0]    rd_addr,
  output logic [WIDTH-1:0] rd_data_p0
);

  logic [WIDTH-1:0] mem [DEPTH];

  // ---- stage p0: array write and registered read ----
  always_ff @(posedge clk) begin
    if (we) begin
      mem[wr_addr] <= wr_data;
    end
    rd_data_p0 <= (we && (wr_addr == rd_addr)) ? wr_data : mem[rd_addr];
  end

endmodule

// File: rtl/tfc_delay_ring.sv
// tfc_delay_ring: programmable delay line for NUM_CH channels sharing one delay.
//   main_clk : single clock, rising edge
//   rst_n    : asynchronous active-low reset
//   bus      : tfc_delay_ring_if.slave (delay request, data in, delayed data
//              out, valid, current delay, sticky error)
// Every cycle tfc_in is written at wr_ptr. The read address is wr_ptr minus
// the delay taking effect on this edge, read through a registered array and
// then a masked output register: data sampled at edge k appears at k+D+1.
// After reset release or any delay load, a fill of D+1 writes must complete
// before the output is unmasked, so stale ring contents never leave the block.
module tfc_delay_ring
  import tfc_delay_pkg::*;
#(
  parameter int DEPTH     = TFC_DEPTH_DEF,
  parameter int TFC_WIDTH = TFC_WIDTH_DEF,
  parameter int NUM_CH    = TFC_NUM_CH_DEF,
  parameter int MAX_DELAY = DEPTH - 1
) (
  input logic             main_clk,
  input logic             rst_n,
  tfc_delay_ring_if.slave bus
);

  localparam int            AW    = $clog2(DEPTH);
  localparam int            BW    = NUM_CH * TFC_WIDTH;
  localparam logic [AW-1:0] MAX_D = AW'(MAX_DELAY);

  tfc_state_e    state_q;
  tfc_state_e    state_nxt;
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] fill_cnt;
  logic [AW-1:0] delay_q;
  logic [AW-1:0] delay_nxt;
  logic          err_q;
  logic          err_nxt;
  logic          fill_restart;
  logic [AW-1:0] rd_addr;
  logic [BW-1:0] rd_data_p0;
  logic [BW-1:0] tfc_out_p1;
  logic          vld_p1;

  // A load always wins over fill completion, even when it repeats the
  // current delay, so every load restarts the fill deterministically.
  always_comb begin
    state_nxt    = state_q;
    delay_nxt    = delay_q;
    err_nxt      = err_q;
    fill_restart = 1'b0;
    if (bus.delay_load) begin
      state_nxt    = FILL;
      fill_restart = 1'b1;
      if (bus.delay_in > MAX_D) begin
        delay_nxt = MAX_D;
        err_nxt   = 1'b1;
      end else begin
        delay_nxt = bus.delay_in;
        err_nxt   = 1'b0;
      end
    end else begin
      unique case (state_q)
        IDLE: begin
          state_nxt    = FILL;
          fill_restart = 1'b1;
        end
        FILL: begin
          // fill_cnt == D means this edge writes entry D+1
          if (fill_cnt == delay_q) begin
            state_nxt = RUN;
          end
        end
        RUN:     state_nxt = RUN;
        default: state_nxt = IDLE;
      endcase
    end
  end

  // Using the delay that takes effect on this edge lets D=0 return the
  // word written on the same edge as the load.
  assign rd_addr = wr_ptr - delay_nxt;

  always_ff @(posedge main_clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      wr_ptr   <= '0;
      fill_cnt <= '0;
      delay_q  <= MAX_D;
      err_q    <= 1'b0;
    end else begin
      state_q <= state_nxt;
      wr_ptr  <= wr_ptr + AW'(1);
      delay_q <= delay_nxt;
      err_q   <= err_nxt;
      if (fill_restart) begin
        fill_cnt <= '0;
      end else if (state_nxt == FILL) begin
        fill_cnt <= fill_cnt + AW'(1);
      end
    end
  end

  tfc_delay_mem #(
    .DEPTH (DEPTH),
    .WIDTH (BW)
  ) u_mem (
    .clk        (main_clk),
    .we         (1'b1),
    .wr_addr    (wr_ptr),
    .wr_data    (bus.tfc_in),
    .rd_addr    (rd_addr),
    .rd_data_p0 (rd_data_p0)
  );

  // ---- stage p1: output register, masked to zero outside RUN ----
  always_ff @(posedge main_clk or negedge rst_n) begin
    if (!rst_n) begin
      tfc_out_p1 <= '0;
      vld_p1     <= 1'b0;
    end else begin
      vld_p1     <= (state_nxt == RUN);
      tfc_out_p1 <= (state_nxt == RUN) ? rd_data_p0 : '0;
    end
  end

  assign bus.tfc_out   = tfc_out_p1;
  assign bus.out_valid = vld_p1;
  assign bus.delay_cur = delay_q;
  assign bus.delay_err = err_q;

endmodule

// File: tb/tb_tfc_delay_ring.sv
// tb_tfc_delay_ring: drives two delay rings (MAX_DELAY 255 and 200) with the
// same stimulus and checks every cycle against a history-array model:
// after the start edge S (reset release or load) with delay D, the output
// at edge m is valid iff m-S >= D+1 and then equals the input of edge m-D-1.
module tb_tfc_delay_ring;
  import tfc_delay_pkg::*;

  localparam int DEPTH = 256;
  localparam int W     = 8;
  localparam int NCH   = 2;
  localparam int AW    = 8;
  localparam int BW    = NCH * W;
  localparam int MAXA  = 255;
  localparam int MAXB  = 200;

  logic main_clk = 1'b0;
  logic rst_n    = 1'b0;
  always #5 main_clk = ~main_clk;

  logic [AW-1:0] s_din;
  logic          s_load;
  logic [BW-1:0] s_in;

  tfc_delay_ring_if #(.DEPTH(DEPTH), .TFC_WIDTH(W), .NUM_CH(NCH)) if_a ();
  tfc_delay_ring_if #(.DEPTH(DEPTH), .TFC_WIDTH(W), .NUM_CH(NCH)) if_b ();

  assign if_a.delay_in   = s_din;
  assign if_a.delay_load = s_load;
  assign if_a.tfc_in     = s_in;
  assign if_b.delay_in   = s_din;
  assign if_b.delay_load = s_load;
  assign if_b.tfc_in     = s_in;

  tfc_delay_ring #(.DEPTH(DEPTH), .TFC_WIDTH(W), .NUM_CH(NCH)) dut_a (
    .main_clk (main_clk),
    .rst_n    (rst_n),
    .bus      (if_a)
  );

  tfc_delay_ring #(.DEPTH(DEPTH), .TFC_WIDTH(W), .NUM_CH(NCH), .MAX_DELAY(MAXB)) dut_b (
    .main_clk (main_clk),
    .rst_n    (rst_n),
    .bus      (if_b)
  );

  int n_cmp  = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, want 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  int            maxd [2];
  int            m_d  [2];
  bit            m_err[2];
  bit            exp_v[2];
  logic [BW-1:0] exp_o[2];
  logic [BW-1:0] hist [1024];
  int            m_edge  = 0;
  int            m_start = 0;
  bit            m_started = 1'b0;

  function automatic void model_reset();
    m_started = 1'b0;
    for (int i = 0; i < 2; i++) begin
      m_d[i]   = maxd[i];
      m_err[i] = 1'b0;
      exp_v[i] = 1'b0;
      exp_o[i] = '0;
    end
  endfunction

  function automatic void model_step();
    hist[m_edge % 1024] = s_in;
    if (s_load) begin
      m_started = 1'b1;
      m_start   = m_edge;
      for (int i = 0; i < 2; i++) begin
        m_err[i] = (int'(s_din) > maxd[i]);
        m_d[i]   = m_err[i] ? maxd[i] : int'(s_din);
      end
    end else if (!m_started) begin
      m_started = 1'b1;
      m_start   = m_edge;
    end
    for (int i = 0; i < 2; i++) begin
      exp_v[i] = m_started && ((m_edge - m_start) >= m_d[i] + 1);
      exp_o[i] = exp_v[i] ? hist[(m_edge - m_d[i] - 1) % 1024] : '0;
    end
    m_edge++;
  endfunction

  // ---------------- per-cycle compare ----------------
  always @(negedge main_clk) begin
    chk("a_valid", 64'(if_a.out_valid), 64'(exp_v[0]));
    chk("a_out",   64'(if_a.tfc_out),   64'(exp_o[0]));
    chk("a_cur",   64'(if_a.delay_cur), 64'(m_d[0]));
    chk("a_err",   64'(if_a.delay_err), 64'(m_err[0]));
    chk("b_valid", 64'(if_b.out_valid), 64'(exp_v[1]));
    chk("b_out",   64'(if_b.tfc_out),   64'(exp_o[1]));
    chk("b_cur",   64'(if_b.delay_cur), 64'(m_d[1]));
    chk("b_err",   64'(if_b.delay_err), 64'(m_err[1]));
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(posedge main_clk);
    if (rst_n) model_step();
    @(negedge main_clk);
  endtask

  task automatic rand_tick();
    s_load = 1'b0;
    s_in   = BW'($urandom);
    tick();
  endtask

  task automatic load_tick(input int din);
    s_load = 1'b1;
    s_din  = AW'(din);
    s_in   = BW'($urandom);
    tick();
    s_load = 1'b0;
  endtask

  // Ticks until each DUT's out_valid first rises; returns -1 if it never does.
  task automatic run_measure(input int budget, output int lat_a, output int lat_b);
    lat_a = -1;
    lat_b = -1;
    for (int k = 1; k <= budget && (lat_a < 0 || lat_b < 0); k++) begin
      rand_tick();
      if (lat_a < 0 && if_a.out_valid === 1'b1) lat_a = k;
      if (lat_b < 0 && if_b.out_valid === 1'b1) lat_b = k;
    end
  endtask

  task automatic async_reset(input string tag, input int hold);
    s_in = BW'($urandom);
    @(posedge main_clk);
    if (rst_n) model_step();
    #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    chk({tag, "_a_valid"}, 64'(if_a.out_valid), 64'(0));
    chk({tag, "_a_out"},   64'(if_a.tfc_out),   64'(0));
    chk({tag, "_a_cur"},   64'(if_a.delay_cur), 64'(MAXA));
    chk({tag, "_b_valid"}, 64'(if_b.out_valid), 64'(0));
    chk({tag, "_b_out"},   64'(if_b.tfc_out),   64'(0));
    chk({tag, "_b_cur"},   64'(if_b.delay_cur), 64'(MAXB));
    chk({tag, "_b_err"},   64'(if_b.delay_err), 64'(0));
    @(negedge main_clk);
    repeat (hold) tick();
    rst_n = 1'b1;
  endtask

  // First edge after release starts the fill with D = MAX_DELAY.
  task automatic powerup_check(input string tag);
    int la, lb;
    rand_tick();
    run_measure(300, la, lb);
    chk({tag, "_lat_a"}, 64'(la), 64'(MAXA + 1));
    chk({tag, "_lat_b"}, 64'(lb), 64'(MAXB + 1));
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- directed + random sequence ----------------
  initial begin
    int            la, lb;
    logic [BW-1:0] l_in, last;
    maxd[0] = MAXA;
    maxd[1] = MAXB;
    model_reset();
    s_load = 1'b0;
    s_din  = '0;
    s_in   = '0;

    repeat (3) tick();
    chk("rst_valid_a", 64'(if_a.out_valid), 64'(0));
    chk("rst_out_a",   64'(if_a.tfc_out),   64'(0));
    chk("rst_cur_a",   64'(if_a.delay_cur), 64'(255));
    chk("rst_cur_b",   64'(if_b.delay_cur), 64'(200));
    chk("rst_err_b",   64'(if_b.delay_err), 64'(0));
    rst_n = 1'b1;
    powerup_check("pwrup0");

    // D=5 with a ramp on channel 0: valid exactly 6 edges after the load
    s_load = 1'b1;
    s_din  = AW'(5);
    s_in   = {8'($urandom), 8'd1};
    tick();
    s_load = 1'b0;
    for (int j = 1; j <= 12; j++) begin
      s_in = {8'($urandom), 8'(j + 1)};
      tick();
      if (j == 5) begin
        chk("d5_early_a", 64'(if_a.out_valid), 64'(0));
        chk("d5_early_b", 64'(if_b.out_valid), 64'(0));
      end
      if (j == 6) begin
        chk("d5_rise_a", 64'(if_a.out_valid), 64'(1));
        chk("d5_rise_b", 64'(if_b.out_valid), 64'(1));
        chk("d5_first",  64'(if_a.tfc_out[7:0]), 64'(1));
        chk("d5_model",  64'(exp_o[0][7:0]), 64'(1));
      end
      if (j == 10) chk("d5_lag", 64'(if_a.tfc_out[7:0]), 64'(5));
    end

    // D=0: one cycle of latency, channels checked independently
    load_tick(0);
    l_in = s_in;
    for (int k = 1; k <= 30; k++) begin
      last = s_in;
      s_in = (k < 10) ? {8'($urandom), 8'hA5} : BW'($urandom);
      tick();
      if (k <= 12) begin
        chk("d0_ch0", 64'(if_a.tfc_out[7:0]),  64'(last[7:0]));
        chk("d0_ch1", 64'(if_b.tfc_out[15:8]), 64'(last[15:8]));
      end
      if (k == 1) chk("d0_first", 64'(if_a.tfc_out), 64'(l_in));
    end

    // Out-of-range request clamps on the MAX_DELAY=200 ring
    load_tick(250);
    chk("clamp_err_b", 64'(if_b.delay_err), 64'(1));
    chk("clamp_cur_b", 64'(if_b.delay_cur), 64'(200));
    chk("clamp_err_a", 64'(if_a.delay_err), 64'(0));
    run_measure(300, la, lb);
    chk("clamp_lat_a", 64'(la), 64'(251));
    chk("clamp_lat_b", 64'(lb), 64'(201));
    load_tick(10);
    chk("clear_err_b", 64'(if_b.delay_err), 64'(0));
    chk("clear_cur_b", 64'(if_b.delay_cur), 64'(10));
    repeat (15) rand_tick();

    // Full-depth delay across several pointer wraps
    load_tick(255);
    chk("d255_cur_a", 64'(if_a.delay_cur), 64'(255));
    run_measure(300, la, lb);
    chk("d255_lat_a", 64'(la), 64'(256));
    repeat (350) rand_tick();

    // Shorter delay while running: output masked, then 4-cycle return
    load_tick(20);
    repeat (30) rand_tick();
    load_tick(3);
    l_in = s_in;
    for (int k = 1; k <= 4; k++) begin
      rand_tick();
      if (k == 1) chk("d3_zero", 64'(if_a.tfc_out), 64'(0));
      if (k < 4) chk("d3_drop", 64'(if_a.out_valid), 64'(0));
      else begin
        chk("d3_back",  64'(if_a.out_valid), 64'(1));
        chk("d3_data",  64'(if_a.tfc_out),   64'(l_in));
        chk("d3_model", 64'(exp_o[0]),       64'(l_in));
      end
    end

    // Load on the completion edge keeps FILL; equal-delay reload restarts
    load_tick(4);
    repeat (4) rand_tick();
    load_tick(6);
    chk("prio_fill", 64'(if_a.out_valid), 64'(0));
    run_measure(20, la, lb);
    chk("prio_lat", 64'(la), 64'(7));
    repeat (5) rand_tick();
    load_tick(6);
    chk("same_drop", 64'(if_b.out_valid), 64'(0));
    run_measure(20, la, lb);
    chk("same_lat", 64'(lb), 64'(7));

    // Asynchronous reset mid-FILL (with error set) and mid-RUN
    load_tick(250);
    repeat (20) rand_tick();
    async_reset("rfill", 2);
    powerup_check("pwrup1");
    repeat (5) rand_tick();
    chk("prerun_a", 64'(if_a.out_valid), 64'(1));
    async_reset("rrun", 3);
    powerup_check("pwrup2");
    repeat (10) rand_tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
